// File: rtl/w4823_fir_pkg.sv
// Shared widths, defaults and FSM state encoding for the W4823 FIR feeder.
package w4823_fir_pkg;

    localparam int FP16_W    = 16;
    localparam int COEF_W    = 17;
    localparam int CADDR_W   = 6;
    localparam int NTAPS_DEF = 64;

    typedef enum logic [1:0] {
        IDLE,
        COEF,
        ISSUE,
        WAIT
    } feeder_state_e;

endpackage

// File: rtl/w4823_fir_feeder_fifo.sv
// Register FIFO for FP16 samples; push is refused when full even if a pop happens that cycle.
module w4823_fir_feeder_fifo
    import w4823_fir_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = FP16_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_FULL);
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage is left unreset; the pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/w4823_fir_feeder.sv
// Feeds the W4823 FIR: loads coefficient bursts and releases one buffered sample per FIR frame.
module w4823_fir_feeder
    import w4823_fir_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int NTAPS         = NTAPS_DEF,
    parameter int FRAME_TIMEOUT = 512
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FP16_W-1:0]  s_data,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [COEF_W-1:0]  c_data,
    input  logic               c_valid,
    output logic               c_ready,
    output logic [FP16_W-1:0]  fir_din,
    output logic               fir_valid_in,
    output logic [COEF_W-1:0]  fir_cin,
    output logic [CADDR_W-1:0] fir_caddr,
    output logic               fir_cload,
    input  logic               fir_valid,
    output logic               coef_loaded,
    output logic               busy,
    output logic               err_timeout
);

    localparam int IDX_W = $clog2(NTAPS);
    localparam int TMR_W = $clog2(FRAME_TIMEOUT + 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NTAPS - 1);
    localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(FRAME_TIMEOUT);

    feeder_state_e      r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [TMR_W-1:0]   r_timer;
    logic               r_fir_valid_d;
    logic [FP16_W-1:0]  r_fir_din;
    logic               r_fir_valid_in;
    logic [COEF_W-1:0]  r_fir_cin;
    logic [CADDR_W-1:0] r_fir_caddr;
    logic               r_fir_cload;
    logic               r_coef_loaded;
    logic               r_err_timeout;

    logic               w_full;
    logic               w_empty;
    logic [FP16_W-1:0]  w_head;
    logic               w_fir_done;
    logic [TMR_W-1:0]   w_timer_inc;

    w4823_fir_feeder_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FP16_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (s_valid),
        .i_data  (s_data),
        .i_pop   (r_state == ISSUE),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    assign w_fir_done  = fir_valid & ~r_fir_valid_d;
    assign w_timer_inc = (r_timer == TMR_LIMIT) ? r_timer : r_timer + TMR_W'(1);

    assign s_ready      = ~w_full;
    assign c_ready      = (r_state == COEF);
    assign busy         = (r_state != IDLE);
    assign fir_din      = r_fir_din;
    assign fir_valid_in = r_fir_valid_in;
    assign fir_cin      = r_fir_cin;
    assign fir_caddr    = r_fir_caddr;
    assign fir_cload    = r_fir_cload;
    assign coef_loaded  = r_coef_loaded;
    assign err_timeout  = r_err_timeout;

    // NOTE: every register here is updated with <= so all of them see pre-edge values in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_idx          <= '0;
            r_timer        <= '0;
            r_fir_valid_d  <= 1'b0;
            r_fir_din      <= '0;
            r_fir_valid_in <= 1'b0;
            r_fir_cin      <= '0;
            r_fir_caddr    <= '0;
            r_fir_cload    <= 1'b0;
            r_coef_loaded  <= 1'b0;
            r_err_timeout  <= 1'b0;
        end else begin
            r_fir_valid_d  <= fir_valid;
            r_fir_valid_in <= 1'b0;
            r_fir_cload    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (c_valid)                         r_state <= COEF;
                    else if (!w_empty && r_coef_loaded)  r_state <= ISSUE;
                end
                COEF: begin
                    if (c_valid) begin
                        r_fir_cin   <= c_data;
                        r_fir_caddr <= CADDR_W'(r_idx);
                        r_fir_cload <= 1'b1;
                        if (r_idx == IDX_LAST) begin
                            r_idx         <= '0;
                            r_coef_loaded <= 1'b1;
                            r_state       <= IDLE;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end
                ISSUE: begin
                    r_fir_din      <= w_head;
                    r_fir_valid_in <= 1'b1;
                    r_timer        <= '0;
                    r_state        <= WAIT;
                end
                WAIT: begin
                    // Only a fresh rising edge of fir_valid closes the frame.
                    if (w_fir_done) begin
                        r_state <= IDLE;
                    end else if (w_timer_inc == TMR_LIMIT) begin
                        r_err_timeout <= 1'b1;
                        r_state       <= IDLE;
                    end else begin
                        r_timer <= w_timer_inc;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_w4823_fir_feeder.sv
// Randomized bench for w4823_fir_feeder with a transaction-level scoreboard of samples, coefficients and frames.
module tb_w4823_fir_feeder;

    localparam int DEPTH   = 4;
    localparam int NTAPS   = 64;
    localparam int TIMEOUT = 512;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [16:0] c_data;
    logic        c_valid;
    logic        c_ready;
    logic [15:0] fir_din;
    logic        fir_valid_in;
    logic [16:0] fir_cin;
    logic [5:0]  fir_caddr;
    logic        fir_cload;
    logic        fir_valid;
    logic        coef_loaded;
    logic        busy;
    logic        err_timeout;

    always #5 clk = ~clk;

    w4823_fir_feeder #(
        .DEPTH         (DEPTH),
        .NTAPS         (NTAPS),
        .FRAME_TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .c_data       (c_data),
        .c_valid      (c_valid),
        .c_ready      (c_ready),
        .fir_din      (fir_din),
        .fir_valid_in (fir_valid_in),
        .fir_cin      (fir_cin),
        .fir_caddr    (fir_caddr),
        .fir_cload    (fir_cload),
        .fir_valid    (fir_valid),
        .coef_loaded  (coef_loaded),
        .busy         (busy),
        .err_timeout  (err_timeout)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: accepted-but-unissued samples, accepted-but-unwritten coefficients, frame status.
    logic [15:0] sq[$];
    logic [16:0] cq[$];
    int          push_cnt, issue_cnt, cload_cnt, wait_cnt;
    bit          inflight, model_loaded, model_err, fv_last;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic monitor();
        if (fir_valid_in) begin
            check("issue_while_inflight", 32'(inflight), 0);
            check("issue_has_sample", 32'(sq.size() > 0), 1);
            if (sq.size() > 0) check("fir_din_order", 32'(fir_din), 32'(sq.pop_front()));
            issue_cnt++;
            inflight = 1'b1;
            wait_cnt = 0;
        end
        if (fir_cload) begin
            check("cload_has_word", 32'(cq.size() > 0), 1);
            if (cq.size() > 0) begin
                check("fir_caddr", 32'(fir_caddr), 32'(cload_cnt % NTAPS));
                check("fir_cin", 32'(fir_cin), 32'(cq.pop_front()));
            end
            cload_cnt++;
            if (cload_cnt % NTAPS == 0) model_loaded = 1'b1;
        end
        check("s_ready", 32'(s_ready), 32'((push_cnt - issue_cnt) < DEPTH));
        check("coef_loaded", 32'(coef_loaded), 32'(model_loaded));
        check("err_timeout", 32'(err_timeout), 32'(model_err));
    endtask

    // Advance one clock; account for handshakes seen at the edge, then observe outputs 1ns later.
    task automatic tick();
        logic        acc, cacc, done, fv_now, rst_now;
        logic [15:0] sd;
        logic [16:0] cd;
        acc     = s_valid && s_ready;
        cacc    = c_valid && c_ready;
        done    = inflight && fir_valid && !fv_last;
        fv_now  = fir_valid;
        rst_now = rst;
        sd      = s_data;
        cd      = c_data;
        @(posedge clk);
        #1;
        fv_last = fv_now;
        if (rst_now) begin
            sq.delete();
            cq.delete();
            push_cnt = 0; issue_cnt = 0; cload_cnt = 0; wait_cnt = 0;
            inflight = 1'b0; model_loaded = 1'b0; model_err = 1'b0; fv_last = 1'b0;
        end else begin
            if (acc) begin
                sq.push_back(sd);
                push_cnt++;
            end
            if (cacc) cq.push_back(cd);
            if (done) begin
                inflight = 1'b0;
            end else if (inflight) begin
                wait_cnt++;
                if (wait_cnt == TIMEOUT) begin
                    model_err = 1'b1;
                    inflight  = 1'b0;
                end
            end
        end
        monitor();
    endtask

    task automatic push_sample(input logic [15:0] d, input int budget, output bit ok);
        logic was;
        s_valid = 1'b1;
        s_data  = d;
        ok      = 1'b0;
        for (int i = 0; i < budget; i++) begin
            was = s_ready;
            tick();
            if (was) begin
                ok = 1'b1;
                break;
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic send_coef(input logic [16:0] d);
        logic was;
        bit   ok = 1'b0;
        c_valid = 1'b1;
        c_data  = d;
        for (int i = 0; i < 200; i++) begin
            was = c_ready;
            tick();
            if (was) begin
                ok = 1'b1;
                break;
            end
        end
        check("coef_accepted", 32'(ok), 1);
    endtask

    task automatic load_burst();
        for (int k = 0; k < NTAPS; k++) send_coef(17'($urandom));
        c_valid = 1'b0;
        check("c_ready_after_burst", 32'(c_ready), 0);
        check("coef_loaded_after_burst", 32'(coef_loaded), 1);
    endtask

    task automatic wait_issue(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (inflight) break;
            tick();
        end
        check("issue_seen", 32'(inflight), 1);
    endtask

    task automatic complete_frame();
        fir_valid = 1'b0;
        tick();
        fir_valid = 1'b1;
        tick();
        fir_valid = 1'b0;
        check("frame_done", 32'(inflight), 0);
        check("busy_after_done", 32'(busy), 0);
    endtask

    task automatic drain();
        for (int g = 0; g < 40; g++) begin
            if (inflight)              complete_frame();
            else if (sq.size() == 0)   break;
            else                       wait_issue(6);
        end
        check("drained", 32'(sq.size()), 0);
    endtask

    initial begin
        bit ok;
        bit took;
        int base;

        rst = 1'b1; s_valid = 1'b0; s_data = '0; c_valid = 1'b0; c_data = '0; fir_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_s_ready", 32'(s_ready), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_c_ready", 32'(c_ready), 0);
        check("rst_fir_valid_in", 32'(fir_valid_in), 0);
        check("rst_fir_cload", 32'(fir_cload), 0);
        check("rst_fir_caddr", 32'(fir_caddr), 0);
        check("rst_fir_din", 32'(fir_din), 0);

        // Samples before the first burst wait in the FIFO.
        push_sample(16'($urandom), 4, ok);
        check("early_push", 32'(ok), 1);
        repeat (6) tick();
        check("no_issue_before_load", 32'(issue_cnt), 0);
        check("idle_before_load", 32'(busy), 0);

        // Full burst; the pending sample must not go out until it completes.
        load_burst();
        check("no_issue_during_burst", 32'(issue_cnt), 0);
        wait_issue(6);
        complete_frame();

        // Latency: accepted at edge t, strobe visible after edge t+2.
        push_sample(16'h3C00, 4, ok);
        check("lat_push", 32'(ok), 1);
        check("lat_t0", 32'(fir_valid_in), 0);
        tick();
        check("lat_t1", 32'(fir_valid_in), 0);
        tick();
        check("lat_t2_strobe", 32'(fir_valid_in), 1);
        check("lat_t2_din", 32'(fir_din), 32'h3C00);
        repeat (5) tick();
        check("hold_fir_din", 32'(fir_din), 32'h3C00);
        complete_frame();

        // fir_valid outside WAIT is ignored; a level already high at WAIT entry is not a completion.
        base = issue_cnt;
        fir_valid = 1'b1;
        tick();
        fir_valid = 1'b0;
        tick();
        check("ignore_idle_fv_busy", 32'(busy), 0);
        check("ignore_idle_fv_issue", 32'(issue_cnt), 32'(base));
        fir_valid = 1'b1;
        push_sample(16'($urandom), 4, ok);
        wait_issue(6);
        repeat (4) tick();
        check("held_fv_still_waiting", 32'(busy), 1);
        complete_frame();

        // Five back-to-back pushes with DEPTH=4: first one issues, remaining four fill the FIFO.
        for (int i = 0; i < 5; i++) push_sample(16'($urandom), 8, ok);
        check("full_after_five", 32'(s_ready), 0);
        push_sample(16'hBEEF, 6, ok);
        check("push_while_full", 32'(ok), 0);

        // Withhold fir_valid: the frame times out on its 512th WAIT cycle.
        for (int i = 0; i < 600 && inflight && wait_cnt < TIMEOUT - 1; i++) tick();
        check("timeout_not_yet", 32'(err_timeout), 0);
        tick();
        check("timeout_flag", 32'(err_timeout), 1);
        check("timeout_to_idle", 32'(busy), 0);
        wait_issue(6);
        push_sample(16'hBEEF, 4, ok);
        check("push_after_pop", 32'(ok), 1);
        drain();

        // Random traffic with stray fir_valid activity.
        took = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!s_valid || took) begin
                s_valid = ($urandom_range(0, 2) == 0);
                s_data  = 16'($urandom);
            end
            fir_valid = ($urandom_range(0, 3) == 0);
            took = s_valid && s_ready;
            tick();
        end
        s_valid   = 1'b0;
        fir_valid = 1'b0;
        tick();
        drain();

        // Reload requested during a frame waits for IDLE and then beats the pending sample.
        push_sample(16'($urandom), 4, ok);
        wait_issue(6);
        push_sample(16'($urandom), 4, ok);
        c_valid = 1'b1;
        c_data  = 17'($urandom);
        repeat (3) tick();
        check("c_ready_blocked_in_wait", 32'(c_ready), 0);
        base = issue_cnt;
        complete_frame();
        load_burst();
        check("reload_before_issue", 32'(issue_cnt), 32'(base));
        drain();

        // Reset in the middle of a burst drops it; the next burst restarts at address 0.
        for (int k = 0; k < 30; k++) send_coef(17'($urandom));
        c_valid = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("midrst_coef_loaded", 32'(coef_loaded), 0);
        check("midrst_caddr", 32'(fir_caddr), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_err", 32'(err_timeout), 0);
        load_burst();
        push_sample(16'($urandom), 4, ok);
        wait_issue(6);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
